gate_stim_checker: RTL and testbench

- Self-checking stimulus/response stage placed around a combinational lab gate (NOT, AND, OR, ...).
- Upstream role: drives the gate's inputs with an exhaustive vector walk.
- Downstream role: samples the gate's output, compares it against the expected function, counts mismatches and reports pass/fail.
- Replaces hand-written initial-block stimulus in the gate benches with a reusable clocked sequencer.

---
 rtl/gate_stim_checker_if.sv | 28 ++
 rtl/gate_stim_checker.sv | 146 ++++++++++++++
 tb/tb_gate_stim_checker.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/gate_stim_checker_if.sv
// Bus between gate_stim_checker and the gate-under-test harness.
// master = checker side, slave = stimulus/gate side.
`timescale 1ns/1ps
interface gate_stim_checker_if #(
    parameter int unsigned N_IN  = 1,
    parameter int unsigned ERR_W = 8
);
    logic              start;
    logic [2:0]        op_sel;
    logic [N_IN-1:0]   dut_in;
    logic              dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic [N_IN-1:0]   fail_idx;
    logic              fail_seen;

    modport master (
        input  start, op_sel, dut_out,
        output dut_in, busy, done, pass, err_count, fail_idx, fail_seen
    );

    modport slave (
        output start, op_sel, dut_out,
        input  dut_in, busy, done, pass, err_count, fail_idx, fail_seen
    );
endinterface

// File: rtl/gate_stim_checker.sv
// Clocked exhaustive stimulus walk plus response checker for a combinational gate.
// Optional macro GSC_STOP_ON_FAIL_EN: end the run at the first mismatch.
`timescale 1ns/1ps
module gate_stim_checker #(
    parameter int unsigned N_IN   = 1,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERR_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    gate_stim_checker_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_APPLY = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int unsigned CNT_W     = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam int unsigned SETTLE_M1 = (SETTLE == 0) ? 0 : SETTLE - 1;
`ifdef GSC_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    logic [2:0]       state_q,     state_d;
    logic [N_IN-1:0]  dut_in_q,    dut_in_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             pass_q,      pass_d;
    logic [ERR_W-1:0] err_q,       err_d;
    logic [N_IN-1:0]  fail_idx_q,  fail_idx_d;
    logic             fail_seen_q, fail_seen_d;
    logic [2:0]       op_q,        op_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             exp_c;
    logic             mismatch_c;

    // Reference function of the gate, evaluated on the applied vector
    always_comb begin
        exp_c = 1'b0;
        case (op_q)
            3'd0:    exp_c = ~dut_in_q[0];
            3'd1:    exp_c =  dut_in_q[0];
            3'd2:    exp_c =  &dut_in_q;
            3'd3:    exp_c =  |dut_in_q;
            3'd4:    exp_c =  ^dut_in_q;
            3'd5:    exp_c = ~&dut_in_q;
            3'd6:    exp_c = ~|dut_in_q;
            default: exp_c = ~^dut_in_q;
        endcase
    end

    // X/Z on the response must count as a failure
    assign mismatch_c = (bus.dut_out !== exp_c);

    always_comb begin
        state_d     = state_q;
        dut_in_d    = dut_in_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_d       = err_q;
        fail_idx_d  = fail_idx_q;
        fail_seen_d = fail_seen_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d     = S_APPLY;
                    dut_in_d    = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_d       = '0;
                    fail_idx_d  = '0;
                    fail_seen_d = 1'b0;
                    op_d        = bus.op_sel;
                end
            end
            S_APPLY: begin
                cnt_d   = CNT_W'(SETTLE_M1);
                state_d = (SETTLE == 0) ? S_CHECK : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_CHECK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_CHECK: begin
                if (mismatch_c) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
                    if (!fail_seen_q) begin
                        fail_idx_d  = dut_in_q;
                        fail_seen_d = 1'b1;
                    end
                end
                if ((STOP_ON_FAIL && mismatch_c) || (dut_in_q == '1)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    dut_in_d = dut_in_q + 1'b1;
                    state_d  = S_APPLY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dut_in_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_idx_q  <= '0;
            fail_seen_q <= 1'b0;
            op_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            dut_in_q    <= dut_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fail_idx_q  <= fail_idx_d;
            fail_seen_q <= fail_seen_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.dut_in    = dut_in_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_idx  = fail_idx_q;
    assign bus.fail_seen = fail_seen_q;
endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed bench for gate_stim_checker: three configurations with modelled gates.
`timescale 1ns/1ps
module tb_gate_stim_checker;
    logic clk = 1'b0;
    logic rst;
    logic stuck_a;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   edges;

    always #5 clk = ~clk;

    gate_stim_checker_if #(.N_IN(1), .ERR_W(8)) if_a ();
    gate_stim_checker_if #(.N_IN(2), .ERR_W(1)) if_b ();
    gate_stim_checker_if #(.N_IN(2), .ERR_W(8)) if_c ();

    gate_stim_checker #(.N_IN(1), .SETTLE(1), .ERR_W(8)) u_a (.clk(clk), .rst(rst), .bus(if_a.master));
    gate_stim_checker #(.N_IN(2), .SETTLE(1), .ERR_W(1)) u_b (.clk(clk), .rst(rst), .bus(if_b.master));
    gate_stim_checker #(.N_IN(2), .SETTLE(0), .ERR_W(8)) u_c (.clk(clk), .rst(rst), .bus(if_c.master));

    // Gate models: inverter (optionally stuck at 0), constant 0, ideal AND
    assign if_a.dut_out = stuck_a ? 1'b0 : ~if_a.dut_in[0];
    assign if_b.dut_out = 1'b0;
    assign if_c.dut_out = &if_c.dut_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic done_of(input int k);
        case (k)
            0:       return if_a.done;
            1:       return if_b.done;
            default: return if_c.done;
        endcase
    endfunction

    function automatic logic busy_of(input int k);
        case (k)
            0:       return if_a.busy;
            1:       return if_b.busy;
            default: return if_c.busy;
        endcase
    endfunction

    task automatic set_start(input int k, input logic s, input logic [2:0] op);
        case (k)
            0:       begin if_a.start = s; if_a.op_sel = op; end
            1:       begin if_b.start = s; if_b.op_sel = op; end
            default: begin if_c.start = s; if_c.op_sel = op; end
        endcase
    endtask

    // One-cycle start pulse, then count edges after the accept edge until done
    task automatic run(input int k, input logic [2:0] op, output int n);
        @(negedge clk);
        set_start(k, 1'b1, op);
        @(posedge clk); #1;
        set_start(k, 1'b0, op);
        check("accept_busy", 32'(busy_of(k)), 1);
        check("accept_done", 32'(done_of(k)), 0);
        n = 0;
        while (!done_of(k) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("run_timeout", 32'(n < 500), 1);
    endtask

    initial begin
        rst = 1'b1;
        stuck_a = 1'b0;
        if_a.start = 1'b0; if_a.op_sel = 3'd0;
        if_b.start = 1'b0; if_b.op_sel = 3'd0;
        if_c.start = 1'b0; if_c.op_sel = 3'd0;
        #2;
        check("rst_dut_in",    32'(if_a.dut_in), 0);
        check("rst_busy",      32'(if_a.busy), 0);
        check("rst_done",      32'(if_a.done), 0);
        check("rst_pass",      32'(if_a.pass), 0);
        check("rst_err",       32'(if_a.err_count), 0);
        check("rst_fail_idx",  32'(if_a.fail_idx), 0);
        check("rst_fail_seen", 32'(if_a.fail_seen), 0);
        @(negedge clk);
        rst = 1'b0;

        // Ideal inverter, NOT
        run(0, 3'd0, edges);
        check("inv_edges",     32'(edges), 6);
        check("inv_dut_in",    32'(if_a.dut_in), 1);
        check("inv_err",       32'(if_a.err_count), 0);
        check("inv_pass",      32'(if_a.pass), 1);
        check("inv_fail_seen", 32'(if_a.fail_seen), 0);
        check("inv_busy",      32'(if_a.busy), 0);

        // Stuck-at-0 output, NOT
        stuck_a = 1'b1;
        run(0, 3'd0, edges);
        check("stuck_err",       32'(if_a.err_count), 1);
        check("stuck_fail_idx",  32'(if_a.fail_idx), 0);
        check("stuck_fail_seen", 32'(if_a.fail_seen), 1);
        check("stuck_pass",      32'(if_a.pass), 0);
`ifdef GSC_STOP_ON_FAIL_EN
        check("stuck_edges",  32'(edges), 3);
        check("stuck_dut_in", 32'(if_a.dut_in), 0);
`else
        check("stuck_edges",  32'(edges), 6);
        check("stuck_dut_in", 32'(if_a.dut_in), 1);
`endif
        stuck_a = 1'b0;

        // start re-pulsed mid-run is ignored
        @(negedge clk);
        set_start(0, 1'b1, 3'd0);
        @(posedge clk); #1;
        set_start(0, 1'b0, 3'd0);
        check("mid_v0", 32'(if_a.dut_in), 0);
        edges = 0;
        repeat (3) begin @(posedge clk); #1; edges++; end
        check("mid_v1", 32'(if_a.dut_in), 1);
        @(negedge clk);
        set_start(0, 1'b1, 3'd1);
        @(posedge clk); #1;
        set_start(0, 1'b0, 3'd0);
        edges++;
        while (!if_a.done && edges < 500) begin @(posedge clk); #1; edges++; end
        check("mid_edges", 32'(edges), 6);
        check("mid_err",   32'(if_a.err_count), 0);
        check("mid_pass",  32'(if_a.pass), 1);

        // rst mid-run aborts and the run does not resume
        @(negedge clk);
        set_start(0, 1'b1, 3'd0);
        @(posedge clk); #1;
        set_start(0, 1'b0, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_dut_in", 32'(if_a.dut_in), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy",   32'(if_a.busy), 0);
        check("arst_dut_in", 32'(if_a.dut_in), 0);
        check("arst_done",   32'(if_a.done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("no_resume_busy", 32'(if_a.busy), 0);
        check("no_resume_done", 32'(if_a.done), 0);
        run(0, 3'd0, edges);
        check("post_rst_edges", 32'(edges), 6);
        check("post_rst_pass",  32'(if_a.pass), 1);

        // Back-to-back: BUF against an inverter from DONE
        run(0, 3'd1, edges);
        check("b2b_fail_idx", 32'(if_a.fail_idx), 0);
        check("b2b_pass",     32'(if_a.pass), 0);
`ifdef GSC_STOP_ON_FAIL_EN
        check("b2b_err",   32'(if_a.err_count), 1);
        check("b2b_edges", 32'(edges), 3);
`else
        check("b2b_err",   32'(if_a.err_count), 2);
        check("b2b_edges", 32'(edges), 6);
`endif

        // XOR expected, output tied 0, 1-bit saturating counter
        run(1, 3'd4, edges);
        check("xor_err",       32'(if_b.err_count), 1);
        check("xor_fail_idx",  32'(if_b.fail_idx), 1);
        check("xor_fail_seen", 32'(if_b.fail_seen), 1);
        check("xor_pass",      32'(if_b.pass), 0);
`ifdef GSC_STOP_ON_FAIL_EN
        check("xor_edges",  32'(edges), 6);
        check("xor_dut_in", 32'(if_b.dut_in), 1);
`else
        check("xor_edges",  32'(edges), 12);
        check("xor_dut_in", 32'(if_b.dut_in), 3);
`endif

        // SETTLE=0, ideal AND
        run(2, 3'd2, edges);
        check("and_edges",  32'(edges), 8);
        check("and_pass",   32'(if_c.pass), 1);
        check("and_err",    32'(if_c.err_count), 0);
        check("and_dut_in", 32'(if_c.dut_in), 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
